// File: rtl/mips_multicycle_controller_pkg.sv
// Shared types and constants for the multicycle MIPS controller.
// Includes the state encoding, opcode/funct/ALU codes, mux selects and the per-state control word.
package mips_ctrl_pkg;

   localparam int unsigned STATE_W = 4;
   localparam int unsigned OP_W    = 6;
   localparam int unsigned FUNCT_W = 6;
   localparam int unsigned ALU_W   = 3;
   localparam int unsigned SEL_W   = 2;

   typedef enum logic [STATE_W-1:0] {
      FETCH   = 4'd0,
      DECODE  = 4'd1,
      MEMADR  = 4'd2,
      MEMRD   = 4'd3,
      MEMWB   = 4'd4,
      MEMWR   = 4'd5,
      RTYPEEX = 4'd6,
      RTYPEWB = 4'd7,
      BRANCH  = 4'd8,
      IMMEX   = 4'd9,
      IMMWB   = 4'd10,
      JUMP    = 4'd11
   } state_t;

   localparam logic [OP_W-1:0] OP_RTYPE = 6'b000000;
   localparam logic [OP_W-1:0] OP_LW    = 6'b100011;
   localparam logic [OP_W-1:0] OP_SW    = 6'b101011;
   localparam logic [OP_W-1:0] OP_BEQ   = 6'b000100;
   localparam logic [OP_W-1:0] OP_BNE   = 6'b000101;
   localparam logic [OP_W-1:0] OP_ADDI  = 6'b001000;
   localparam logic [OP_W-1:0] OP_ANDI  = 6'b001100;
   localparam logic [OP_W-1:0] OP_ORI   = 6'b001101;
   localparam logic [OP_W-1:0] OP_J     = 6'b000010;

   localparam logic [FUNCT_W-1:0] FN_ADD = 6'b100000;
   localparam logic [FUNCT_W-1:0] FN_SUB = 6'b100010;
   localparam logic [FUNCT_W-1:0] FN_AND = 6'b100100;
   localparam logic [FUNCT_W-1:0] FN_OR  = 6'b100101;
   localparam logic [FUNCT_W-1:0] FN_SLT = 6'b101010;

   localparam logic [ALU_W-1:0] ALU_AND = 3'b000;
   localparam logic [ALU_W-1:0] ALU_OR  = 3'b001;
   localparam logic [ALU_W-1:0] ALU_ADD = 3'b010;
   localparam logic [ALU_W-1:0] ALU_SUB = 3'b110;
   localparam logic [ALU_W-1:0] ALU_SLT = 3'b111;

   localparam logic [SEL_W-1:0] SRCB_RT    = 2'b00;
   localparam logic [SEL_W-1:0] SRCB_FOUR  = 2'b01;
   localparam logic [SEL_W-1:0] SRCB_IMM   = 2'b10;
   localparam logic [SEL_W-1:0] SRCB_BRIMM = 2'b11;

   localparam logic [SEL_W-1:0] PCSRC_ALU    = 2'b00;
   localparam logic [SEL_W-1:0] PCSRC_ALUOUT = 2'b01;
   localparam logic [SEL_W-1:0] PCSRC_JUMP   = 2'b10;

   // Control outputs that depend only on the state (plus the stable IR fields).
   typedef struct packed {
      logic             mem_req;
      logic             memwrite;
      logic             iord;
      logic             regwrite;
      logic             regdst;
      logic             memtoreg;
      logic             alusrca;
      logic [SEL_W-1:0] alusrcb;
      logic             zeroextend;
      logic [SEL_W-1:0] pcsrc;
      logic [ALU_W-1:0] alucontrol;
   } ctrl_t;

   function automatic logic [ALU_W-1:0] imm_alu(logic [OP_W-1:0] op);
      case (op)
         OP_ANDI: return ALU_AND;
         OP_ORI:  return ALU_OR;
         default: return ALU_ADD;
      endcase
   endfunction

   // Control word presented while the FSM sits in state s.
   function automatic ctrl_t state_ctrl(state_t s, logic [OP_W-1:0] op,
                                        logic [ALU_W-1:0] rtype_alu);
      ctrl_t c;
      c = '0;
      case (s)
         FETCH: begin
            c.mem_req    = 1'b1;
            c.alusrcb    = SRCB_FOUR;
            c.alucontrol = ALU_ADD;
            c.pcsrc      = PCSRC_ALU;
         end
         DECODE: begin
            c.alusrcb    = SRCB_BRIMM;
            c.alucontrol = ALU_ADD;
         end
         MEMADR: begin
            c.alusrca    = 1'b1;
            c.alusrcb    = SRCB_IMM;
            c.alucontrol = ALU_ADD;
         end
         MEMRD: begin
            c.mem_req = 1'b1;
            c.iord    = 1'b1;
         end
         MEMWB: begin
            c.regwrite = 1'b1;
            c.memtoreg = 1'b1;
         end
         MEMWR: begin
            c.mem_req  = 1'b1;
            c.memwrite = 1'b1;
            c.iord     = 1'b1;
         end
         RTYPEEX: begin
            c.alusrca    = 1'b1;
            c.alusrcb    = SRCB_RT;
            c.alucontrol = rtype_alu;
         end
         RTYPEWB: begin
            c.regwrite = 1'b1;
            c.regdst   = 1'b1;
         end
         BRANCH: begin
            c.alusrca    = 1'b1;
            c.alusrcb    = SRCB_RT;
            c.alucontrol = ALU_SUB;
            c.pcsrc      = PCSRC_ALUOUT;
         end
         IMMEX: begin
            c.alusrca    = 1'b1;
            c.alusrcb    = SRCB_IMM;
            c.zeroextend = (op != OP_ADDI);
            c.alucontrol = imm_alu(op);
         end
         IMMWB: begin
            c.regwrite   = 1'b1;
            c.zeroextend = (op != OP_ADDI);
         end
         JUMP: begin
            c.pcsrc = PCSRC_JUMP;
         end
         default: ;
      endcase
      return c;
   endfunction

endpackage

// File: rtl/mips_multicycle_controller_if.sv
// Controller <-> datapath/memory bundle: IR fields and flags in, control strobes and selects out.
interface mips_multicycle_controller_if;
   import mips_ctrl_pkg::*;

   logic [OP_W-1:0]    op;
   logic [FUNCT_W-1:0] funct;
   logic               zero;
   logic               mem_ready;
   logic               mem_req;
   logic               memwrite;
   logic               iord;
   logic               irwrite;
   logic               pcen;
   logic               regwrite;
   logic               regdst;
   logic               memtoreg;
   logic               alusrca;
   logic [SEL_W-1:0]   alusrcb;
   logic               zeroextend;
   logic [SEL_W-1:0]   pcsrc;
   logic [ALU_W-1:0]   alucontrol;
   logic [STATE_W-1:0] state;
   logic               illegal;

   modport master (
      input  op, funct, zero, mem_ready,
      output mem_req, memwrite, iord, irwrite, pcen, regwrite, regdst, memtoreg,
             alusrca, alusrcb, zeroextend, pcsrc, alucontrol, state, illegal
   );

   modport slave (
      output op, funct, zero, mem_ready,
      input  mem_req, memwrite, iord, irwrite, pcen, regwrite, regdst, memtoreg,
             alusrca, alusrcb, zeroextend, pcsrc, alucontrol, state, illegal
   );
endinterface

// File: rtl/mips_multicycle_controller_aludec.sv
// R-type ALU decoder: maps funct to alucontrol and flags unsupported funct codes.
module mips_aludec
   import mips_ctrl_pkg::*;
(
   input  logic [FUNCT_W-1:0] funct,
   output logic [ALU_W-1:0]   alucontrol,
   output logic               illegal
);

   always_comb begin
      alucontrol = ALU_AND;
      illegal    = 1'b0;
      case (funct)
         FN_ADD:  alucontrol = ALU_ADD;
         FN_SUB:  alucontrol = ALU_SUB;
         FN_AND:  alucontrol = ALU_AND;
         FN_OR:   alucontrol = ALU_OR;
         FN_SLT:  alucontrol = ALU_SLT;
         default: illegal = 1'b1;
      endcase
   end

endmodule

// File: rtl/mips_multicycle_controller.sv
// Main control FSM for the shared-memory multicycle MIPS datapath.
// Defining MIPS_PERF_CNT_EN adds cycle_cnt/instr_cnt performance counters.
module mips_multicycle_controller
   import mips_ctrl_pkg::*;
`ifdef MIPS_PERF_CNT_EN
#(
   parameter int unsigned CNT_W = 32
)
`endif
(
   input  logic                         clk,
   input  logic                         reset,
   mips_multicycle_controller_if.master bus
`ifdef MIPS_PERF_CNT_EN
   ,
   output logic [CNT_W-1:0]             cycle_cnt,
   output logic [CNT_W-1:0]             instr_cnt
`endif
);

   state_t           state_q;
   state_t           state_d;
   ctrl_t            ctrl_q;
   logic [ALU_W-1:0] rtype_alu;
   logic             bad_funct;
   logic             irwrite_c;
   logic             pcen_c;
   logic             illegal_c;

   mips_aludec u_aludec (
      .funct      (bus.funct),
      .alucontrol (rtype_alu),
      .illegal    (bad_funct)
   );

   // Next state plus the strobes that react to same-cycle inputs (mem_ready, zero, op, funct).
   always_comb begin
      state_d   = FETCH;
      irwrite_c = 1'b0;
      pcen_c    = 1'b0;
      illegal_c = 1'b0;
      case (state_q)
         FETCH: begin
            if (bus.mem_ready) begin
               irwrite_c = 1'b1;
               pcen_c    = 1'b1;
               state_d   = DECODE;
            end else begin
               state_d = FETCH;
            end
         end
         DECODE: begin
            case (bus.op)
               OP_LW, OP_SW:           state_d = MEMADR;
               OP_RTYPE:               state_d = RTYPEEX;
               OP_BEQ, OP_BNE:         state_d = BRANCH;
               OP_ADDI, OP_ANDI, OP_ORI: state_d = IMMEX;
               OP_J:                   state_d = JUMP;
               default: begin
                  illegal_c = 1'b1;
                  state_d   = FETCH;
               end
            endcase
         end
         MEMADR:  state_d = (bus.op == OP_SW) ? MEMWR : MEMRD;
         MEMRD:   state_d = bus.mem_ready ? MEMWB : MEMRD;
         MEMWB:   state_d = FETCH;
         MEMWR:   state_d = bus.mem_ready ? FETCH : MEMWR;
         RTYPEEX: begin
            if (bad_funct) begin
               illegal_c = 1'b1;
               state_d   = FETCH;
            end else begin
               state_d = RTYPEWB;
            end
         end
         RTYPEWB: state_d = FETCH;
         BRANCH: begin
            pcen_c  = (bus.op == OP_BNE) ? ~bus.zero : bus.zero;
            state_d = FETCH;
         end
         IMMEX:   state_d = IMMWB;
         IMMWB:   state_d = FETCH;
         JUMP: begin
            pcen_c  = 1'b1;
            state_d = FETCH;
         end
         default: state_d = FETCH;
      endcase
      // Reset suppresses every strobe so nothing is written while the FSM is held.
      if (!reset) begin
         irwrite_c = 1'b0;
         pcen_c    = 1'b0;
         illegal_c = 1'b0;
      end
   end

   // State register with the state-only control word registered alongside it.
   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q <= FETCH;
         ctrl_q  <= state_ctrl(FETCH, bus.op, rtype_alu);
      end else begin
         state_q <= state_d;
         ctrl_q  <= state_ctrl(state_d, bus.op, rtype_alu);
      end
   end

   assign bus.mem_req    = ctrl_q.mem_req;
   assign bus.memwrite   = ctrl_q.memwrite;
   assign bus.iord       = ctrl_q.iord;
   assign bus.regwrite   = ctrl_q.regwrite;
   assign bus.regdst     = ctrl_q.regdst;
   assign bus.memtoreg   = ctrl_q.memtoreg;
   assign bus.alusrca    = ctrl_q.alusrca;
   assign bus.alusrcb    = ctrl_q.alusrcb;
   assign bus.zeroextend = ctrl_q.zeroextend;
   assign bus.pcsrc      = ctrl_q.pcsrc;
   assign bus.alucontrol = reset ? ctrl_q.alucontrol : '0;
   assign bus.state      = state_q;
   assign bus.irwrite    = irwrite_c;
   assign bus.pcen       = pcen_c;
   assign bus.illegal    = illegal_c;

`ifdef MIPS_PERF_CNT_EN
   // Retired-instruction count skips the return to FETCH after an illegal decode.
   always_ff @(posedge clk) begin
      if (!reset) begin
         cycle_cnt <= '0;
         instr_cnt <= '0;
      end else begin
         cycle_cnt <= cycle_cnt + CNT_W'(1);
         if ((state_q != FETCH) && (state_d == FETCH) && !illegal_c) begin
            instr_cnt <= instr_cnt + CNT_W'(1);
         end
      end
   end
`endif

endmodule
